// File: rtl/life_controller.sv
// Game-flow controller: ghost hit test, lives count, death freeze and idle/game-over/win states.
// Latency: lifeDown/restart are registered and appear one Clk after the deciding edge.
// Backpressure: none; inputs are sampled every Clk and pulses cannot be stalled.
module life_controller #(
    parameter int         START_LIVES = 3,
    parameter int         DEATH_SECS  = 2,
    parameter logic [7:0] START_KEY   = 8'h2C
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        sec,
    input  logic [7:0]  keycode,
    input  logic [9:0]  pX,
    input  logic [9:0]  pY,
    input  logic [9:0]  pS,
    input  logic [9:0]  gX0,
    input  logic [9:0]  gX1,
    input  logic [9:0]  gX2,
    input  logic [9:0]  gX3,
    input  logic [9:0]  gY0,
    input  logic [9:0]  gY1,
    input  logic [9:0]  gY2,
    input  logic [9:0]  gY3,
    input  logic [9:0]  gS0,
    input  logic [9:0]  gS1,
    input  logic [9:0]  gS2,
    input  logic [9:0]  gS3,
    input  logic [31:0] dots_left,
    output logic        lifeDown,
    output logic        restart,
    output logic [2:0]  lives,
    output logic        freeze,
    output logic        game_over,
    output logic        win,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DEATH     = 3'd2,
        ST_GAME_OVER = 3'd3,
        ST_WIN       = 3'd4
    } state_t;

    // Seconds counter only needs to reach DEATH_SECS-1 before the freeze ends.
    localparam int               SEC_W      = (DEATH_SECS > 1) ? $clog2(DEATH_SECS) : 1;
    localparam logic [SEC_W-1:0] LAST_SEC   = SEC_W'(DEATH_SECS - 1);
    localparam logic [2:0]       LIVES_INIT = 3'(START_LIVES);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_lives;
    logic [2:0]       w_lives_nxt;
    logic [SEC_W-1:0] r_sec_cnt;
    logic [SEC_W-1:0] w_sec_cnt_nxt;
    logic             r_frame_q;
    logic             r_life_down;
    logic             w_life_down_nxt;
    logic             r_restart;
    logic             w_restart_nxt;
    logic             r_armed;

    logic             w_frame_rise;
    logic             w_start;
    logic             w_hit;
    logic [9:0]       w_gx [4];
    logic [9:0]       w_gy [4];
    logic [9:0]       w_gs [4];

    assign w_gx[0] = gX0;
    assign w_gx[1] = gX1;
    assign w_gx[2] = gX2;
    assign w_gx[3] = gX3;
    assign w_gy[0] = gY0;
    assign w_gy[1] = gY1;
    assign w_gy[2] = gY2;
    assign w_gy[3] = gY3;
    assign w_gs[0] = gS0;
    assign w_gs[1] = gS1;
    assign w_gs[2] = gS2;
    assign w_gs[3] = gS3;

    assign w_frame_rise = frame_clk & ~r_frame_q;
    assign w_start      = (keycode == START_KEY);

    // Unsigned distance widened to 11 bits so it compares cleanly against a summed radius.
    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

    // Box overlap against each ghost; touching exactly (distance == radius sum) is not a hit.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((abs_diff(pX, w_gx[i]) < ({1'b0, pS} + {1'b0, w_gs[i]})) &&
                (abs_diff(pY, w_gy[i]) < ({1'b0, pS} + {1'b0, w_gs[i]}))) begin
                w_hit = 1'b1;
            end
        end
    end

    // State, lives, second counter and the registered pulses.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state     <= ST_IDLE;
            r_lives     <= LIVES_INIT;
            r_sec_cnt   <= '0;
            r_frame_q   <= 1'b0;
            r_life_down <= 1'b0;
            r_restart   <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lives     <= w_lives_nxt;
            r_sec_cnt   <= w_sec_cnt_nxt;
            r_frame_q   <= frame_clk;
            r_life_down <= w_life_down_nxt;
            r_restart   <= w_restart_nxt;
            r_armed     <= 1'b1;
        end
    end

    // Next-state logic. A start key on the first edge after reset release is dropped
    // (r_armed still low) so reset always wins over a key already held down.
    always_comb begin
        w_state_nxt     = r_state;
        w_lives_nxt     = r_lives;
        w_sec_cnt_nxt   = r_sec_cnt;
        w_life_down_nxt = 1'b0;
        w_restart_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start && r_armed) begin
                    w_lives_nxt   = LIVES_INIT;
                    w_restart_nxt = 1'b1;
                    w_state_nxt   = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_frame_rise) begin
                    if (dots_left == 32'd0) begin
                        w_state_nxt = ST_WIN;
                    end else if (w_hit) begin
                        w_life_down_nxt = 1'b1;
                        w_lives_nxt     = (r_lives == 3'd0) ? 3'd0 : r_lives - 3'd1;
                        w_sec_cnt_nxt   = '0;
                        w_state_nxt     = ST_DEATH;
                    end
                end
            end
            ST_DEATH: begin
                if (sec) begin
                    if (r_sec_cnt == LAST_SEC) begin
                        w_sec_cnt_nxt = '0;
                        if (r_lives == 3'd0) begin
                            w_state_nxt = ST_GAME_OVER;
                        end else begin
                            w_restart_nxt = 1'b1;
                            w_state_nxt   = ST_PLAY;
                        end
                    end else begin
                        w_sec_cnt_nxt = r_sec_cnt + SEC_W'(1);
                    end
                end
            end
            ST_GAME_OVER, ST_WIN: begin
                if (w_start) begin
                    w_lives_nxt   = LIVES_INIT;
                    w_restart_nxt = 1'b1;
                    w_state_nxt   = ST_PLAY;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign lifeDown  = r_life_down;
    assign restart   = r_restart;
    assign lives     = r_lives;
    assign state     = r_state;
    assign freeze    = (r_state != ST_PLAY);
    assign game_over = (r_state == ST_GAME_OVER);
    assign win       = (r_state == ST_WIN);

endmodule

// File: tb/tb_life_controller.sv
// Testbench for life_controller: event scoreboard against a game-rule model.
// Latency: expects each event on the outputs one Clk after the deciding edge.
// Backpressure: none; monitor compares every observed pulse or state change.
module tb_life_controller;

    localparam int S_IDLE = 0;
    localparam int S_PLAY = 1;
    localparam int S_DEATH = 2;
    localparam int S_GO = 3;
    localparam int S_WIN = 4;
    localparam int START = 3;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk, sec;
    logic [7:0]  keycode;
    logic [9:0]  pX, pY, pS;
    logic [9:0]  gX0, gX1, gX2, gX3, gY0, gY1, gY2, gY3, gS0, gS1, gS2, gS3;
    logic [31:0] dots_left;
    logic        lifeDown, restart, freeze, game_over, win;
    logic [2:0]  lives, state;

    life_controller dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .sec(sec), .keycode(keycode),
        .pX(pX), .pY(pY), .pS(pS),
        .gX0(gX0), .gX1(gX1), .gX2(gX2), .gX3(gX3),
        .gY0(gY0), .gY1(gY1), .gY2(gY2), .gY3(gY3),
        .gS0(gS0), .gS1(gS1), .gS2(gS2), .gS3(gS3),
        .dots_left(dots_left), .lifeDown(lifeDown), .restart(restart), .lives(lives),
        .freeze(freeze), .game_over(game_over), .win(win), .state(state)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       rs;
        logic       ld;
        logic [2:0] st;
        logic [2:0] lv;
        logic       fz;
        logic       go;
        logic       wn;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  failures = 0;
    int  m_state, m_lives, m_sec;

    function automatic ev_t mk(input logic rs, input logic ld, input int st, input int lv);
        ev_t e;
        e.rs = rs;
        e.ld = ld;
        e.st = 3'(st);
        e.lv = 3'(lv);
        e.fz = (st != S_PLAY);
        e.go = (st == S_GO);
        e.wn = (st == S_WIN);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    // Monitor: any pulse or state change is an event that must match the head of the queue.
    initial begin
        logic [2:0] prev_state;
        logic       prev_pulse;
        ev_t        obs, exp;
        prev_state = 3'd0;
        prev_pulse = 1'b0;
        forever begin
            @(negedge Clk);
            obs = '{rs: restart, ld: lifeDown, st: state, lv: lives,
                    fz: freeze, go: game_over, wn: win};
            if (restart || lifeDown || state != prev_state) begin
                if (restart || lifeDown) begin
                    checks++;
                    if (prev_pulse) begin
                        failures++;
                        $display("FAIL pulse_back_to_back at %0t", $time);
                    end
                end
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event got=%b expected=none at %0t", obs, $time);
                end else begin
                    exp = q.pop_front();
                    if (obs !== exp) begin
                        failures++;
                        $display("FAIL event got rs=%0b ld=%0b st=%0d lv=%0d fz/go/wn=%b%b%b expected rs=%0b ld=%0b st=%0d lv=%0d fz/go/wn=%b%b%b at %0t",
                                 obs.rs, obs.ld, obs.st, obs.lv, obs.fz, obs.go, obs.wn,
                                 exp.rs, exp.ld, exp.st, exp.lv, exp.fz, exp.go, exp.wn, $time);
                    end
                end
            end
            prev_state = state;
            prev_pulse = restart | lifeDown;
        end
    end

    // Rule-level hit test: overlap on both axes, strict inequality.
    function automatic bit model_hit();
        int gx[4];
        int gy[4];
        int gs[4];
        int dx, dy;
        bit h;
        gx = '{int'(gX0), int'(gX1), int'(gX2), int'(gX3)};
        gy = '{int'(gY0), int'(gY1), int'(gY2), int'(gY3)};
        gs = '{int'(gS0), int'(gS1), int'(gS2), int'(gS3)};
        h = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dx = int'(pX) - gx[i];
            dy = int'(pY) - gy[i];
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            if (dx < int'(pS) + gs[i] && dy < int'(pS) + gs[i]) h = 1'b1;
        end
        return h;
    endfunction

    task automatic quiet(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(m_state));
        chk({tag, "_lives"}, 32'(lives), 32'(m_lives));
        chk({tag, "_freeze"}, 32'(freeze), 32'(m_state != S_PLAY));
    endtask

    task automatic press_start();
        if (m_state == S_IDLE || m_state == S_GO || m_state == S_WIN) begin
            m_lives = START;
            m_state = S_PLAY;
            q.push_back(mk(1'b1, 1'b0, S_PLAY, START));
        end
        keycode = 8'h2C;
        cyc();
        cyc();
        keycode = 8'h00;
        cyc();
    endtask

    task automatic frame();
        if (m_state == S_PLAY) begin
            if (dots_left == 32'd0) begin
                m_state = S_WIN;
                q.push_back(mk(1'b0, 1'b0, S_WIN, m_lives));
            end else if (model_hit()) begin
                m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                m_state = S_DEATH;
                m_sec = 0;
                q.push_back(mk(1'b0, 1'b1, S_DEATH, m_lives));
            end
        end
        frame_clk = 1'b1;
        repeat (3) cyc();
        frame_clk = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic sec_pulse();
        if (m_state == S_DEATH) begin
            m_sec++;
            if (m_sec == 2) begin
                if (m_lives == 0) begin
                    m_state = S_GO;
                    q.push_back(mk(1'b0, 1'b0, S_GO, 0));
                end else begin
                    m_state = S_PLAY;
                    q.push_back(mk(1'b1, 1'b0, S_PLAY, m_lives));
                end
            end
        end
        sec = 1'b1;
        cyc();
        sec = 1'b0;
        cyc();
    endtask

    task automatic park();
        {gX0, gX1, gX2, gX3} = {4{10'd1000}};
        {gY0, gY1, gY2, gY3} = {4{10'd1000}};
        {gS0, gS1, gS2, gS3} = {4{10'd0}};
    endtask

    task automatic rand_pos();
        pX = 10'($urandom_range(0, 80));  pY = 10'($urandom_range(0, 80));
        pS = 10'($urandom_range(0, 12));
        gX0 = 10'($urandom_range(0, 80)); gY0 = 10'($urandom_range(0, 80)); gS0 = 10'($urandom_range(0, 12));
        gX1 = 10'($urandom_range(0, 80)); gY1 = 10'($urandom_range(0, 80)); gS1 = 10'($urandom_range(0, 12));
        gX2 = 10'($urandom_range(0, 80)); gY2 = 10'($urandom_range(0, 80)); gS2 = 10'($urandom_range(0, 12));
        gX3 = 10'($urandom_range(0, 80)); gY3 = 10'($urandom_range(0, 80)); gS3 = 10'($urandom_range(0, 12));
        dots_left = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 500));
    endtask

    initial begin
        Reset = 1'b0;
        frame_clk = 1'b0;
        sec = 1'b0;
        keycode = 8'h00;
        pX = 10'd100; pY = 10'd100; pS = 10'd6;
        park();
        dots_left = 32'd100;
        m_state = S_IDLE;
        m_lives = START;
        m_sec = 0;

        repeat (3) cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_pulses", 32'({lifeDown, restart}), 32'd0);
        chk("rst_flags", 32'({freeze, game_over, win}), 32'b100);
        Reset = 1'b1;
        repeat (2) cyc();

        press_start();
        quiet("start");

        // Boundary: distance equal to radius sum on either axis is no hit.
        gX2 = 10'd112; gY2 = 10'd100; gS2 = 10'd6;
        frame();
        gX2 = 10'd100; gY2 = 10'd88;
        frame();
        quiet("edge_nohit");
        gX2 = 10'd110; gY2 = 10'd100;
        frame();
        quiet("hit1");
        sec_pulse();
        quiet("death_one_sec");
        sec_pulse();
        quiet("revive1");

        frame();
        repeat (2) sec_pulse();
        frame();
        quiet("hit3");
        sec_pulse();
        sec_pulse();
        quiet("game_over");
        chk("game_over_flag", 32'(game_over), 32'd1);
        press_start();
        quiet("restart_go");

        dots_left = 32'd0;
        frame();
        quiet("win");
        chk("win_flag", 32'(win), 32'd1);
        dots_left = 32'd100;
        press_start();
        quiet("restart_win");

        frame();
        sec_pulse();
        q.push_back(mk(1'b0, 1'b0, S_IDLE, START));
        Reset = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_lives", 32'(lives), 32'd3);
        m_state = S_IDLE;
        m_lives = START;
        repeat (2) cyc();
        keycode = 8'h2C;
        Reset = 1'b1;
        cyc();
        keycode = 8'h00;
        cyc();
        quiet("key_at_release");
        repeat (3) frame();
        quiet("idle_frames");
        press_start();

        for (int n = 0; n < 200; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 5) begin
                rand_pos();
                frame();
            end else if (r <= 7) begin
                sec_pulse();
            end else begin
                press_start();
            end
            if (n % 20 == 0) quiet("rand");
        end

        repeat (5) cyc();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
